// File: rtl/imem_loader.sv
// Boot-time program loader: assembles a little-endian byte stream into 32-bit words for the
// instruction memory write port and holds the core in reset until the image is in place.
// Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);
  localparam int              MAX_WORDS   = 2 ** ADDR_W;
  localparam logic [16:0]     MAX_WORDS_C = 17'(MAX_WORDS);
  localparam logic [ADDR_W:0] ONE         = {{ADDR_W{1'b0}}, 1'b1};

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR} state_t;
  localparam state_t S_END = S_CSUM;
`else
  typedef enum logic [2:0] {S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERROR} state_t;
  localparam state_t S_END = S_DONE;
`endif

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
  logic [ADDR_W:0]   word_idx_q, word_idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       asm_q, asm_d;
  logic              accept;
  logic [16:0]       len_ext;
  logic [ADDR_W:0]   word_idx_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign accept       = in_valid && in_ready_q;
  assign len_ext      = {1'b0, in_data, len_lo_q};
  assign word_idx_inc = word_idx_q + ONE;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign asm_d[gi*8 +: 8] = (accept && state_q == S_DATA && byte_idx_q == 2'(gi))
                              ? in_data : asm_q[gi*8 +: 8];
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_comb begin
    csum_d = csum_q;
    if (accept && state_q != S_CSUM) csum_d = csum_q ^ in_data;
  end
`endif

  always_comb begin
    state_d        = state_q;
    len_lo_d       = len_lo_q;
    len_d          = len_q;
    byte_idx_d     = byte_idx_q;
    word_idx_d     = word_idx_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    words_loaded_d = imem_we_q ? words_loaded_q + ONE : words_loaded_q;
    if (accept) begin
      case (state_q)
        S_LEN_LO: begin
          len_lo_d = in_data;
          state_d  = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_d = len_ext[ADDR_W:0];
          if (len_ext > MAX_WORDS_C)  state_d = S_ERROR;
          else if (len_ext == 17'd0)  state_d = S_END;
          else                        state_d = S_DATA;
        end
        S_DATA: begin
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx_q[ADDR_W-1:0];
            imem_wdata_d = asm_d;
            word_idx_d   = word_idx_inc;
            if (word_idx_inc == len_q) state_d = S_END;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
`endif
        default: state_d = state_q;
      endcase
    end
    in_ready_d = !(state_d == S_DONE || state_d == S_ERROR);
    // Leaving DATA straight to DONE delays done one cycle so the final write commits first.
    done_d     = (state_d == S_DONE) && (state_q != S_DATA);
    error_d    = (state_d == S_ERROR);
    cpu_rst_d  = !done_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_LEN_LO;
      in_ready_q     <= 1'b1;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      cpu_rst_q      <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= '0;
      word_idx_q     <= '0;
      len_q          <= '0;
      len_lo_q       <= '0;
      byte_idx_q     <= '0;
      asm_q          <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      cpu_rst_q      <= cpu_rst_d;
      done_q         <= done_d;
      error_q        <= error_d;
      words_loaded_q <= words_loaded_d;
      word_idx_q     <= word_idx_d;
      len_q          <= len_d;
      len_lo_q       <= len_lo_d;
      byte_idx_q     <= byte_idx_d;
      asm_q          <= asm_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q         <= csum_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign cpu_rst      = cpu_rst_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;
endmodule
